// File: rtl/serial_sub4bit.sv
// -----------------------------------------------------------------------------
// serial_sub4bit
//
// Bit-serial subtractor: computes in1 - in2 - bin one bit per clock, LSB first,
// using a single 1-bit full-subtractor cell and a borrow flip-flop.
//
// Parameters
//   WIDTH   operand / result width in bits (>= 2)
//
// Ports
//   clk     clock, all state updates on the rising edge
//   rst_n   asynchronous active-low reset
//   start   request; only looked at while idle
//   in1     minuend, captured when a start is accepted
//   in2     subtrahend, captured when a start is accepted
//   bin     borrow-in, captured when a start is accepted
//   busy    high while an operation is running or completing (RUN/DONE)
//   done    one-cycle pulse, out/borrow hold the new result
//   out     difference, (in1 - in2 - bin) mod 2^WIDTH
//   borrow  borrow-out, 1 when in1 < in2 + bin (unsigned)
//
// Timing: a start sampled at edge T0 gives RUN for WIDTH cycles and done=1 in
// the cycle after edge T0+WIDTH. The next start can be accepted in the IDLE
// cycle that follows DONE. Starts seen in RUN or DONE are dropped.
// -----------------------------------------------------------------------------
module serial_sub4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // minuend shift register
    logic [WIDTH-1:0] b_q, b_d;       // subtrahend shift register
    logic [WIDTH-1:0] res_q, res_d;   // partial difference, filled from the MSB end
    logic             br_q, br_d;     // running borrow
    logic [WIDTH-1:0] out_q, out_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor cell on the current LSBs.
    logic a_bit, b_bit, diff_bit, br_next;

    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        diff_bit = a_bit ^ b_bit ^ br_q;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        out_d    = out_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                // After WIDTH shifts the first (LSB) difference bit sits at res[0].
                res_d = {diff_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Only the completed result is ever copied to the outputs.
                    out_d    = {diff_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next-state decode so they
        // line up with the state they describe.
        busy_d = (state_d == RUN) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out    = out_q;
    assign borrow = borrow_q;

endmodule
